// File: rtl/wb_dbus_master.sv
// wb_dbus_master: CPU data-side Wishbone classic master.
// Turns a single-cycle MEM-stage load/store request into one Wishbone
// cycle, stalls the pipeline until ack, and returns the load data. If the
// pipeline is still stalled by another source when the ack arrives, the
// load result is held in a read buffer until the stall clears. A flush
// aborts an outstanding cycle.
// Optional feature: define WB_TIMEOUT_EN to abort a cycle that sees no ack
// within TIMEOUT_CYCLES BUSY cycles; bus_err_o pulses and 32'hDEADBEEF is
// returned. Without the macro, BUSY waits for ack indefinitely and
// bus_err_o is tied low.

module wb_dbus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_req_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  state_t      state_r, state_nxt_s;
  logic        cyc_r, cyc_nxt_s;
  logic        we_r, we_nxt_s;
  logic [31:0] adr_r, adr_nxt_s;
  logic [31:0] dat_r, dat_nxt_s;
  logic [3:0]  sel_r, sel_nxt_s;
  logic [31:0] rbuf_r, rbuf_nxt_s;
  logic        stall_req_s;
  logic        bus_err_s;
  logic [31:0] rdata_s;
  logic        timeout_hit_s;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_r;

  // Saturating count of BUSY cycles; held at zero outside BUSY so it restarts on entry
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != BUSY) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (tmo_cnt_r != CNT_LAST) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Last allowed BUSY cycle with no ack; a flush in the same cycle wins
  assign timeout_hit_s = (state_r == BUSY) && (tmo_cnt_r == CNT_LAST) &&
                         !wb_ack_i && !flush_i;
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state, next bus register values and combinational CPU-side outputs
  always_comb begin
    state_nxt_s = state_r;
    cyc_nxt_s   = cyc_r;
    we_nxt_s    = we_r;
    adr_nxt_s   = adr_r;
    dat_nxt_s   = dat_r;
    sel_nxt_s   = sel_r;
    rbuf_nxt_s  = rbuf_r;
    stall_req_s = 1'b0;
    bus_err_s   = 1'b0;
    rdata_s     = 32'h0000_0000;

    case (state_r)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stall_req_s = 1'b1;
          state_nxt_s = BUSY;
          cyc_nxt_s   = 1'b1;
          we_nxt_s    = cpu_we_i;
          adr_nxt_s   = cpu_addr_i;
          dat_nxt_s   = cpu_wdata_i;
          sel_nxt_s   = cpu_sel_i;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      BUSY: begin
        if (flush_i) begin
          // Abort; any read data in this cycle is dropped
          stall_req_s = !wb_ack_i;
          state_nxt_s = IDLE;
          cyc_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
        end else if (wb_ack_i) begin
          rdata_s     = we_r ? 32'h0000_0000 : wb_dat_i;
          rbuf_nxt_s  = we_r ? rbuf_r : wb_dat_i;
          state_nxt_s = stall_i ? WAIT_STALL : IDLE;
          cyc_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
        end else if (timeout_hit_s) begin
          bus_err_s   = 1'b1;
          rdata_s     = ERR_DATA;
          cyc_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
          if (stall_i) begin
            state_nxt_s = WAIT_STALL;
            rbuf_nxt_s  = ERR_DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          stall_req_s = 1'b1;
        end
      end

      WAIT_STALL: begin
        rdata_s = rbuf_r;
        if (!stall_i || flush_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_STALL;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        cyc_nxt_s   = 1'b0;
        we_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and Wishbone output registers; reset clears the bus asynchronously
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r <= IDLE;
      cyc_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= 32'h0000_0000;
      dat_r   <= 32'h0000_0000;
      sel_r   <= 4'b0000;
      rbuf_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cyc_r   <= cyc_nxt_s;
      we_r    <= we_nxt_s;
      adr_r   <= adr_nxt_s;
      dat_r   <= dat_nxt_s;
      sel_r   <= sel_nxt_s;
      rbuf_r  <= rbuf_nxt_s;
    end
  end

  // Strobe shares the cycle flop, so it can never be asserted without cyc
  assign wb_cyc_o    = cyc_r;
  assign wb_stb_o    = cyc_r;
  assign wb_we_o     = we_r;
  assign wb_adr_o    = adr_r;
  assign wb_dat_o    = dat_r;
  assign wb_sel_o    = sel_r;
  assign stall_req_o = stall_req_s;
  assign cpu_rdata_o = rdata_s;
  assign bus_err_o   = bus_err_s;

endmodule

// File: tb/tb_wb_dbus_master.sv
// Testbench for wb_dbus_master: directed accesses against a behavioural
// Wishbone slave with programmable ack delay. Every access pushes its
// expected bus fields and read data into a scoreboard queue; a monitor pops
// and compares whenever the slave acks. Flow checks (stall counts, WAIT_STALL
// data, flush, reset, timeout) are made inline.

module tb_wb_dbus_master;

  logic        clk;
  logic        rst_n;
  logic        cpu_ce, cpu_we, stall_i, flush_i;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_rdata;
  logic        stall_req;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, bus_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int ack_delay;
  int busy_cnt;

  wb_dbus_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .cpu_ce_i    (cpu_ce),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_sel_i   (cpu_sel),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .stall_req_o (stall_req),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack),
    .bus_err_o   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: counts BUSY cycles and acks combinationally after ack_delay
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (wb_cyc && !wb_ack) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end
  assign wb_ack = wb_cyc & wb_stb & (busy_cnt == ack_delay);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Scoreboard monitor: compare every acked transfer against the queue head
  always @(negedge clk) begin
    if (rst_n && wb_cyc && wb_ack) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL mon_unexpected_ack: got ack at adr %h, expected no transfer", wb_adr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mon_adr",   wb_adr,    mon_e.adr);
        chk("mon_we",    {31'b0, wb_we},  {31'b0, mon_e.we});
        chk("mon_sel",   {28'b0, wb_sel}, {28'b0, mon_e.sel});
        chk("mon_stb",   {31'b0, wb_stb}, 32'd1);
        if (mon_e.we) chk("mon_wdat", wb_dat_o, mon_e.wdat);
        chk("mon_rdata", cpu_rdata, mon_e.rdat);
        chk("mon_stall", {31'b0, stall_req}, 32'd0);
        chk("mon_berr",  {31'b0, bus_err},   32'd0);
      end
    end
  end

  // One complete access: request, BUSY until ack, optional WAIT_STALL, IDLE
  task automatic access(input string tag, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input logic [31:0] rdat, input int dly, input int hold,
                        input logic [31:0] exp_buf);
    exp_t e;
    int stalls, strobes, adr_bad;
    logic acked;
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = we; cpu_addr = adr; cpu_sel = sel; cpu_wdata = wdat;
    wb_dat_i = rdat; ack_delay = dly; stall_i = (hold > 0);
    e.adr = adr; e.we = we; e.sel = sel; e.wdat = wdat;
    e.rdat = we ? 32'h0 : rdat;
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, "_req_stall"}, {31'b0, stall_req}, 32'd1);
    chk({tag, "_req_cyc"},   {31'b0, wb_cyc},    32'd0);
    stalls = 1; strobes = 0; adr_bad = 0; acked = 1'b0;
    @(posedge clk); #1;
    // Scramble the request inputs: BUSY must ignore them
    cpu_ce = 1'b0; cpu_we = ~we; cpu_addr = ~adr; cpu_sel = ~sel; cpu_wdata = ~wdat;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wb_stb) strobes++;
      if (stall_req) stalls++;
      if (wb_adr !== adr) adr_bad++;
      if (wb_ack) acked = 1'b1;
      if (wb_ack || !wb_cyc) break;
    end
    chk({tag, "_acked"},   {31'b0, acked}, 32'd1);
    chk({tag, "_stalls"},  stalls,  dly + 1);
    chk({tag, "_strobes"}, strobes, dly + 1);
    chk({tag, "_adr_stable"}, adr_bad, 32'd0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_ws_rdata"}, cpu_rdata, exp_buf);
        chk({tag, "_ws_cyc"},   {31'b0, wb_cyc},    32'd0);
        chk({tag, "_ws_stall"}, {31'b0, stall_req}, 32'd0);
      end
      @(posedge clk); #1; stall_i = 1'b0;
      @(negedge clk);
      chk({tag, "_ws_last_rdata"}, cpu_rdata, exp_buf);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_idle_stall"}, {31'b0, stall_req}, 32'd0);
    chk({tag, "_idle_cyc"},   {31'b0, wb_cyc},    32'd0);
  endtask

  // Start a load that the slave never acks; returns just after entering BUSY
  task automatic start_no_ack(input logic [31:0] adr, input logic [31:0] wdat);
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = adr; cpu_sel = 4'b1111; cpu_wdata = wdat;
    ack_delay = 1000;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_sel = 4'b0;
    cpu_wdata = 32'h0; stall_i = 1'b0; flush_i = 1'b0; wb_dat_i = 32'h0; ack_delay = 0;
    #12;
    chk("rst_cyc",   {31'b0, wb_cyc},    32'd0);
    chk("rst_stb",   {31'b0, wb_stb},    32'd0);
    chk("rst_we",    {31'b0, wb_we},     32'd0);
    chk("rst_adr",   wb_adr,             32'h0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_rdata", cpu_rdata,          32'h0);
    chk("rst_berr",  {31'b0, bus_err},   32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Store straight after reset into WAIT_STALL exposes the cleared buffer
    access("store1", 1'b1, 32'hBFAF_F010, 4'b1111, 32'h1234_5678, 32'h0, 0, 1, 32'h0);
    access("load1",  1'b0, 32'hBFAF_F020, 4'b1111, 32'h0, 32'h0000_00A5, 0, 0, 32'h0);
    access("load_dly3", 1'b0, 32'hBFAF_F024, 4'b0011, 32'h0, 32'h5A5A_0003, 3, 0, 32'h0);
    access("load_ws",  1'b0, 32'hBFAF_F028, 4'b1111, 32'h0, 32'hCAFE_0001, 1, 3, 32'hCAFE_0001);
    // Store must not overwrite the read buffer
    access("store_ws", 1'b1, 32'hBFAF_F030, 4'b0100, 32'h00AB_0000, 32'h0, 0, 1, 32'hCAFE_0001);

    // Flush mid-BUSY before ack
    start_no_ack(32'hBFAF_F040, 32'h0);
    @(negedge clk);
    chk("flush_busy_cyc", {31'b0, wb_cyc}, 32'd1);
    @(posedge clk); #1; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_cyc",   {31'b0, wb_cyc},    32'd0);
    chk("flush_stb",   {31'b0, wb_stb},    32'd0);
    chk("flush_stall", {31'b0, stall_req}, 32'd0);

    // Asynchronous reset mid-BUSY
    start_no_ack(32'h1000_0004, 32'hFFFF_0000);
    @(negedge clk);
    chk("rst2_pre_cyc", {31'b0, wb_cyc}, 32'd1);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("rst2_cyc",   {31'b0, wb_cyc},    32'd0);
    chk("rst2_stb",   {31'b0, wb_stb},    32'd0);
    chk("rst2_adr",   wb_adr,             32'h0);
    chk("rst2_dat",   wb_dat_o,           32'h0);
    chk("rst2_sel",   {28'b0, wb_sel},    32'd0);
    chk("rst2_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    // Buffer was cleared by reset (it held 32'hCAFE0001 before)
    access("store_post_rst", 1'b1, 32'hBFAF_F010, 4'b0001, 32'h0000_0077, 32'h0, 0, 1, 32'h0);

`ifdef WB_TIMEOUT_EN
    start_no_ack(32'hBFAF_F050, 32'h0);
    bad = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus_err !== 1'b0 || stall_req !== 1'b1 || wb_cyc !== 1'b1) bad++;
    end
    chk("tmo_pre_cycles_bad", bad, 32'd0);
    @(negedge clk);
    chk("tmo_berr",  {31'b0, bus_err},   32'd1);
    chk("tmo_rdata", cpu_rdata,          32'hDEAD_BEEF);
    chk("tmo_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_cyc_drop", {31'b0, wb_cyc},  32'd0);
    chk("tmo_berr_off", {31'b0, bus_err}, 32'd0);
    // Timeout while stalled leaves the error word in the buffer
    start_no_ack(32'hBFAF_F054, 32'h0);
    stall_i = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("tmo2_berr", {31'b0, bus_err}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo2_ws_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("tmo2_ws_cyc",   {31'b0, wb_cyc}, 32'd0);
    @(posedge clk); #1; stall_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo2_idle_rdata", cpu_rdata, 32'h0);
`else
    start_no_ack(32'hBFAF_F050, 32'h0);
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_err !== 1'b0 || stall_req !== 1'b1 || wb_cyc !== 1'b1) bad++;
    end
    chk("noto_wait_bad", bad, 32'd0);
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    chk("noto_abort_cyc", {31'b0, wb_cyc}, 32'd0);
`endif

    access("load_final", 1'b0, 32'hBFAF_F060, 4'b1000, 32'h0, 32'h8765_4321, 2, 0, 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
